// File: rtl/issue_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : issue_dispatcher
// Brief    : In-order single-issue dispatcher with register scoreboard and
//            branch/CSR serialisation. Optional stall counters under
//            DISPATCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module issue_dispatcher #(
    parameter int ISSUE_Q_WIDTH = 123,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int FU_NUM        = 4,
    parameter int REG_NUM       = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_q_rok,
    input  logic [ISSUE_Q_WIDTH-1:0] issue_q_rdata,
    output logic                     issue_q_ren,
    output logic [FU_NUM-1:0]        fu_valid,
    input  logic [FU_NUM-1:0]        fu_ready,
    output logic [ISSUE_Q_WIDTH-1:0] fu_payload,
    input  logic [FU_NUM-1:0]        wb_valid,
    input  logic [FU_NUM*5-1:0]      wb_rd,
    input  logic                     br_resolve,
    input  logic                     flush,
`ifdef DISPATCH_PERF_CNT_EN
    output logic [31:0]              stall_raw_cnt,
    output logic [31:0]              stall_ser_cnt,
`endif
    output logic                     busy
);

    localparam int c_WEN = 2 * ADDR_WIDTH + 1;
    localparam int c_RD  = 2 * ADDR_WIDTH + 2;
    localparam int c_RS2 = 2 * ADDR_WIDTH + 7;
    localparam int c_RS1 = 2 * ADDR_WIDTH + 12;
    localparam int c_FLG = 2 * ADDR_WIDTH + 17 + DATA_WIDTH;
    localparam int c_FN  = c_FLG + 8;

    localparam logic [1:0] c_FN_BPU = 2'd2;
    localparam logic [1:0] c_FN_CSR = 2'd3;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_BR_WAIT  = 2'd1,
        S_SER_WAIT = 2'd2
    } state_t;

    state_t                    r_state;
    logic                      r_slot_valid;
    logic [ISSUE_Q_WIDTH-1:0]  r_slot;
    logic [REG_NUM-1:0]        r_sb;

    logic [1:0]                w_head_fn;
    logic [3:0]                w_head_flg;
    logic [4:0]                w_head_rs1;
    logic [4:0]                w_head_rs2;
    logic [4:0]                w_head_rd;
    logic                      w_head_wen;
    logic [1:0]                w_slot_fn;
    logic                      w_accept;
    logic                      w_slot_free;
    logic                      w_hazard;
    logic                      w_sb_zero;
    logic                      w_csr_ok;
    logic                      w_dispatch;
    logic [REG_NUM-1:0]        w_set;
    logic [REG_NUM-1:0]        w_clr;
    logic [REG_NUM-1:0]        w_clr_fu [FU_NUM];

    assign w_head_fn  = issue_q_rdata[c_FN +: 2];
    assign w_head_flg = issue_q_rdata[c_FLG +: 4];
    assign w_head_rs1 = issue_q_rdata[c_RS1 +: 5];
    assign w_head_rs2 = issue_q_rdata[c_RS2 +: 5];
    assign w_head_rd  = issue_q_rdata[c_RD +: 5];
    assign w_head_wen = issue_q_rdata[c_WEN];
    assign w_slot_fn  = r_slot[c_FN +: 2];

    generate
        for (genvar i = 0; i < FU_NUM; i++) begin : g_fu_valid
            assign fu_valid[i] = r_slot_valid && (32'(w_slot_fn) == i);
        end
        for (genvar i = 0; i < FU_NUM; i++) begin : g_wb
            assign w_clr_fu[i] = wb_valid[i] ? (REG_NUM'(1) << wb_rd[5*i +: 5]) : '0;
        end
    endgenerate

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            w_clr = w_clr | w_clr_fu[i];
        end
    end

    assign w_accept    = |(fu_valid & fu_ready);
    assign w_slot_free = !r_slot_valid || w_accept;
    assign w_sb_zero   = ~|r_sb;

    // x0 is hardwired, so it never participates in hazard detection
    assign w_hazard = (w_head_flg[3] && (w_head_rs1 != 5'd0) && r_sb[w_head_rs1]) ||
                      (w_head_flg[2] && (w_head_rs2 != 5'd0) && r_sb[w_head_rs2]) ||
                      (w_head_wen    && (w_head_rd  != 5'd0) && r_sb[w_head_rd]);

    // CSR needs a truly empty pipeline: an accepting slot is not enough
    assign w_csr_ok = (w_head_fn != c_FN_CSR) || (!r_slot_valid && w_sb_zero);

    assign w_dispatch = issue_q_rok && w_slot_free && !w_hazard &&
                        (r_state == S_RUN) && !flush && w_csr_ok;

    assign w_set = (w_dispatch && w_head_wen && (w_head_rd != 5'd0)) ?
                   (REG_NUM'(1) << w_head_rd) : '0;

    assign issue_q_ren = w_dispatch;
    assign fu_payload  = r_slot;
    assign busy        = r_slot_valid || !w_sb_zero || (r_state != S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_valid <= 1'b0;
            r_slot       <= '0;
            r_sb         <= '0;
            r_state      <= S_RUN;
        end else begin
            r_sb <= (r_sb & ~w_clr) | w_set;
            if (flush) begin
                r_slot_valid <= 1'b0;
            end else if (w_dispatch) begin
                r_slot_valid <= 1'b1;
                r_slot       <= issue_q_rdata;
            end else if (w_accept) begin
                r_slot_valid <= 1'b0;
            end
            if (flush) begin
                r_state <= S_RUN;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (w_dispatch && (w_head_fn == c_FN_BPU)) begin
                            r_state <= S_BR_WAIT;
                        end else if (w_dispatch && (w_head_fn == c_FN_CSR)) begin
                            r_state <= S_SER_WAIT;
                        end
                    end
                    S_BR_WAIT: begin
                        if (br_resolve) begin
                            r_state <= S_RUN;
                        end
                    end
                    S_SER_WAIT: begin
                        if (!r_slot_valid && w_sb_zero) begin
                            r_state <= S_RUN;
                        end
                    end
                    default: r_state <= S_RUN;
                endcase
            end
        end
    end

`ifdef DISPATCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_raw_cnt <= '0;
            stall_ser_cnt <= '0;
        end else begin
            if (issue_q_rok && w_hazard && (stall_raw_cnt != 32'hFFFF_FFFF)) begin
                stall_raw_cnt <= stall_raw_cnt + 32'd1;
            end
            if (issue_q_rok && ((r_state != S_RUN) || !w_csr_ok) &&
                (stall_ser_cnt != 32'hFFFF_FFFF)) begin
                stall_ser_cnt <= stall_ser_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_dispatcher
// Brief    : Cycle-by-cycle vector table plus reset-mid-operation sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_dispatcher;

    logic         clk;
    logic         rst_n;
    logic         issue_q_rok;
    logic [122:0] issue_q_rdata;
    logic         issue_q_ren;
    logic [3:0]   fu_valid;
    logic [3:0]   fu_ready;
    logic [122:0] fu_payload;
    logic [3:0]   wb_valid;
    logic [19:0]  wb_rd;
    logic         br_resolve;
    logic         flush;
    logic         busy;

    int errors = 0;
    int checks = 0;

    issue_dispatcher dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_q_rok   (issue_q_rok),
        .issue_q_rdata (issue_q_rdata),
        .issue_q_ren   (issue_q_ren),
        .fu_valid      (fu_valid),
        .fu_ready      (fu_ready),
        .fu_payload    (fu_payload),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .br_resolve    (br_resolve),
        .flush         (flush),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rok;
        logic [122:0] data;
        logic [3:0]   rdy;
        logic [3:0]   wbv;
        logic [19:0]  wbrd;
        logic         br;
        logic         fl;
        logic         e_ren;
        logic [3:0]   e_fv;
        logic         e_busy;
        logic         chk_pl;
        logic [122:0] e_pl;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [122:0] mk(input logic [1:0] fn, input logic [3:0] fl,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [4:0] rd, input logic wen,
                                         input logic [31:0] imm, input logic [31:0] pc);
        logic [122:0] e;
        e = '0;
        e[122:121] = fn;
        e[120:117] = 4'd1;
        e[116:113] = fl;
        e[112:81]  = imm;
        e[80:76]   = rs1;
        e[75:71]   = rs2;
        e[70:66]   = rd;
        e[65]      = wen;
        e[64]      = 1'b0;
        e[63:32]   = pc + 32'd4;
        e[31:0]    = pc;
        return e;
    endfunction

    function automatic logic [19:0] wr(input int fu, input logic [4:0] rd);
        logic [19:0] v;
        v = '0;
        v[5*fu +: 5] = rd;
        return v;
    endfunction

    task automatic add(input logic rok, input logic [122:0] data, input logic [3:0] rdy,
                       input logic [3:0] wbv, input logic [19:0] wbrd, input logic br,
                       input logic fl, input logic e_ren, input logic [3:0] e_fv,
                       input logic e_busy, input logic chk_pl, input logic [122:0] e_pl);
        vec_t v;
        v.rok = rok; v.data = data; v.rdy = rdy; v.wbv = wbv; v.wbrd = wbrd;
        v.br = br; v.fl = fl; v.e_ren = e_ren; v.e_fv = e_fv; v.e_busy = e_busy;
        v.chk_pl = chk_pl; v.e_pl = e_pl;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        issue_q_rok   = 1'b0;
        issue_q_rdata = '0;
        fu_ready      = '0;
        wb_valid      = '0;
        wb_rd         = '0;
        br_resolve    = 1'b0;
        flush         = 1'b0;
    endtask

    initial begin
        logic [122:0] a_x1, b_x2, c_x3, d_x4, e_ld5, f_csr6, g_x7, h_beq, i_x8, j_use1, z;
        a_x1   = mk(2'd0, 4'b1100, 5'd0, 5'd0, 5'd1, 1'b1, 32'd0,  32'h1000);
        b_x2   = mk(2'd0, 4'b1010, 5'd0, 5'd0, 5'd2, 1'b1, 32'd7,  32'h1004);
        c_x3   = mk(2'd0, 4'b1100, 5'd0, 5'd0, 5'd3, 1'b1, 32'd0,  32'h1008);
        d_x4   = mk(2'd0, 4'b1000, 5'd3, 5'd0, 5'd4, 1'b1, 32'd0,  32'h100C);
        e_ld5  = mk(2'd1, 4'b1010, 5'd0, 5'd0, 5'd5, 1'b1, 32'h10, 32'h1010);
        f_csr6 = mk(2'd3, 4'b1000, 5'd0, 5'd0, 5'd6, 1'b1, 32'h300, 32'h1014);
        g_x7   = mk(2'd0, 4'b1100, 5'd0, 5'd0, 5'd7, 1'b1, 32'd0,  32'h1018);
        h_beq  = mk(2'd2, 4'b1100, 5'd0, 5'd0, 5'd0, 1'b0, 32'h40, 32'h101C);
        i_x8   = mk(2'd0, 4'b1100, 5'd0, 5'd0, 5'd8, 1'b1, 32'd0,  32'h1020);
        j_use1 = mk(2'd0, 4'b1000, 5'd1, 5'd0, 5'd0, 1'b0, 32'd0,  32'h1024);
        z      = '0;

        // back-to-back ALU, then release x1 and x2 separately
        add(1, a_x1, 4'b0001, 4'b0000, 20'd0, 0, 0, 1, 4'b0000, 0, 0, z);
        add(1, b_x2, 4'b0001, 4'b0000, 20'd0, 0, 0, 1, 4'b0001, 1, 1, a_x1);
        add(0, z,    4'b0001, 4'b0000, 20'd0, 0, 0, 0, 4'b0001, 1, 1, b_x2);
        add(0, z,    4'b0001, 4'b0001, wr(0, 5'd1), 0, 0, 0, 4'b0000, 1, 0, z);
        add(0, z,    4'b0001, 4'b0010, wr(1, 5'd2), 0, 0, 0, 4'b0000, 1, 0, z);
        // RAW stall on x3: held four cycles, pops after the writeback cycle
        add(1, c_x3, 4'b0001, 4'b0000, 20'd0, 0, 0, 1, 4'b0000, 0, 0, z);
        add(1, d_x4, 4'b0001, 4'b0000, 20'd0, 0, 0, 0, 4'b0001, 1, 0, z);
        add(1, d_x4, 4'b0001, 4'b0000, 20'd0, 0, 0, 0, 4'b0000, 1, 0, z);
        add(1, d_x4, 4'b0001, 4'b0000, 20'd0, 0, 0, 0, 4'b0000, 1, 0, z);
        add(1, d_x4, 4'b0001, 4'b0001, wr(0, 5'd3), 0, 0, 0, 4'b0000, 1, 0, z);
        add(1, d_x4, 4'b0001, 4'b0000, 20'd0, 0, 0, 1, 4'b0000, 0, 0, z);
        add(0, z,    4'b0001, 4'b0000, 20'd0, 0, 0, 0, 4'b0001, 1, 1, d_x4);
        add(0, z,    4'b0001, 4'b0001, wr(0, 5'd4), 0, 0, 0, 4'b0000, 1, 0, z);
        // LSU backpressure with a CSR waiting behind it
        add(1, e_ld5,  4'b0000, 4'b0000, 20'd0, 0, 0, 1, 4'b0000, 0, 0, z);
        add(1, f_csr6, 4'b0000, 4'b0000, 20'd0, 0, 0, 0, 4'b0010, 1, 1, e_ld5);
        add(1, f_csr6, 4'b0000, 4'b0000, 20'd0, 0, 0, 0, 4'b0010, 1, 1, e_ld5);
        add(1, f_csr6, 4'b0000, 4'b0000, 20'd0, 0, 0, 0, 4'b0010, 1, 1, e_ld5);
        add(1, f_csr6, 4'b0010, 4'b0000, 20'd0, 0, 0, 0, 4'b0010, 1, 1, e_ld5);
        // CSR drain: waits for x5 writeback, then serialises behind itself
        add(1, f_csr6, 4'b0000, 4'b0000, 20'd0, 0, 0, 0, 4'b0000, 1, 0, z);
        add(1, f_csr6, 4'b0000, 4'b0010, wr(1, 5'd5), 0, 0, 0, 4'b0000, 1, 0, z);
        add(1, f_csr6, 4'b0000, 4'b0000, 20'd0, 0, 0, 1, 4'b0000, 0, 0, z);
        add(1, g_x7,   4'b1000, 4'b0000, 20'd0, 0, 0, 0, 4'b1000, 1, 1, f_csr6);
        add(1, g_x7,   4'b0000, 4'b0000, 20'd0, 0, 0, 0, 4'b0000, 1, 0, z);
        add(1, g_x7,   4'b0000, 4'b1000, wr(3, 5'd6), 0, 0, 0, 4'b0000, 1, 0, z);
        add(1, g_x7,   4'b0001, 4'b0000, 20'd0, 0, 0, 0, 4'b0000, 1, 0, z);
        add(1, g_x7,   4'b0001, 4'b0000, 20'd0, 0, 0, 1, 4'b0000, 0, 0, z);
        add(0, z,      4'b0001, 4'b0000, 20'd0, 0, 0, 0, 4'b0001, 1, 1, g_x7);
        add(0, z,      4'b0001, 4'b0001, wr(0, 5'd7), 0, 0, 0, 4'b0000, 1, 0, z);
        // branch serialisation with resolve
        add(1, h_beq, 4'b0100, 4'b0000, 20'd0, 0, 0, 1, 4'b0000, 0, 0, z);
        add(1, i_x8,  4'b0101, 4'b0000, 20'd0, 0, 0, 0, 4'b0100, 1, 1, h_beq);
        add(1, i_x8,  4'b0101, 4'b0000, 20'd0, 0, 0, 0, 4'b0000, 1, 0, z);
        add(1, i_x8,  4'b0101, 4'b0000, 20'd0, 1, 0, 0, 4'b0000, 1, 0, z);
        add(1, i_x8,  4'b0101, 4'b0000, 20'd0, 0, 0, 1, 4'b0000, 0, 0, z);
        add(0, z,     4'b0001, 4'b0000, 20'd0, 0, 0, 0, 4'b0001, 1, 1, i_x8);
        add(0, z,     4'b0001, 4'b0001, wr(0, 5'd8), 0, 0, 0, 4'b0000, 1, 0, z);
        // branch serialisation with flush: slot dropped although FU is ready
        add(1, h_beq, 4'b0000, 4'b0000, 20'd0, 0, 0, 1, 4'b0000, 0, 0, z);
        add(1, i_x8,  4'b0100, 4'b0000, 20'd0, 0, 1, 0, 4'b0100, 1, 1, h_beq);
        add(1, i_x8,  4'b0001, 4'b0000, 20'd0, 0, 0, 1, 4'b0000, 0, 0, z);
        add(0, z,     4'b0001, 4'b0000, 20'd0, 0, 0, 0, 4'b0001, 1, 1, i_x8);
        add(0, z,     4'b0001, 4'b0001, wr(0, 5'd8), 0, 0, 0, 4'b0000, 1, 0, z);
        add(0, z,     4'b0000, 4'b0000, 20'd0, 0, 0, 0, 4'b0000, 0, 0, z);

        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ren",     128'(issue_q_ren), 128'(1'b0));
        check("reset_fu_valid", 128'(fu_valid),   128'(4'b0000));
        check("reset_payload",  128'(fu_payload), 128'(0));
        check("reset_busy",     128'(busy),       128'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            issue_q_rok   = tbl[i].rok;
            issue_q_rdata = tbl[i].data;
            fu_ready      = tbl[i].rdy;
            wb_valid      = tbl[i].wbv;
            wb_rd         = tbl[i].wbrd;
            br_resolve    = tbl[i].br;
            flush         = tbl[i].fl;
            #1;
            check($sformatf("v%0d_ren", i),      128'(issue_q_ren), 128'(tbl[i].e_ren));
            check($sformatf("v%0d_fu_valid", i), 128'(fu_valid),    128'(tbl[i].e_fv));
            check($sformatf("v%0d_busy", i),     128'(busy),        128'(tbl[i].e_busy));
            if (tbl[i].chk_pl) begin
                check($sformatf("v%0d_payload", i), 128'(fu_payload), 128'(tbl[i].e_pl));
            end
        end

        // asynchronous reset while slot and scoreboard are occupied
        @(negedge clk);
        idle_inputs();
        issue_q_rok   = 1'b1;
        issue_q_rdata = a_x1;
        #1 check("mid_pop", 128'(issue_q_ren), 128'(1'b1));
        @(negedge clk);
        idle_inputs();
        #1;
        check("mid_fu_valid", 128'(fu_valid), 128'(4'b0001));
        check("mid_busy",     128'(busy),     128'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("async_fu_valid", 128'(fu_valid),   128'(4'b0000));
        check("async_busy",     128'(busy),       128'(1'b0));
        check("async_payload",  128'(fu_payload), 128'(0));
        @(negedge clk);
        rst_n         = 1'b1;
        issue_q_rok   = 1'b1;
        issue_q_rdata = j_use1;
        fu_ready      = 4'b0001;
        #1 check("post_reset_no_raw_x1", 128'(issue_q_ren), 128'(1'b1));
        @(negedge clk);
        idle_inputs();
        #1 check("post_reset_fu_valid", 128'(fu_valid), 128'(4'b0001));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_dispatcher.md
Name: issue_dispatcher

Overview:
- In-order, single-issue dispatcher between the issue queue and the four function units (ALU=0, LSU=1, BPU=2, CSR=3).
- Pops one decoded entry per cycle and checks RAW/WAW hazards against a 32-entry register scoreboard.
- Holds the entry in a registered dispatch slot until the target FU accepts it.
- Serialises control flow: after a branch, waits for BPU resolution. A CSR op issues only into an empty pipeline, and nothing follows it until the pipeline drains again.

Parameters:
- ISSUE_Q_WIDTH, 123, width of one issue-queue entry.
- ADDR_WIDTH, 32, PC width.
- DATA_WIDTH, 32, immediate width.
- FU_NUM, 4, number of function units (one valid/ready pair each).
- REG_NUM, 32, architectural registers tracked by the scoreboard.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_q_rok  in  1  issue-queue head valid.
- issue_q_rdata  in  ISSUE_Q_WIDTH  head entry. Fields: [122:121] function, [120:117] operator, [116:113] operand flags {rs1,rs2,imm,pc}, [112:81] imm, [80:76] rs1, [75:71] rs2, [70:66] rd, [65] rd_wen, [64] taken, [63:32] nxt_pc, [31:0] cur_pc.
- issue_q_ren  out  1  pop head; asserted only in a cycle where issue_q_rok=1.
- fu_valid  out  FU_NUM  one-hot; bit = slot function field while slot valid.
- fu_ready  in  FU_NUM  FU accepts the slot when its valid and ready are both 1.
- fu_payload  out  ISSUE_Q_WIDTH  registered slot contents, shared by all FUs.
- wb_valid  in  FU_NUM  per-FU writeback strobe.
- wb_rd  in  FU_NUM*5  per-FU writeback register, FU i at [5i+:5].
- br_resolve  in  1  BPU resolution pulse for the outstanding branch.
- flush  in  1  synchronous pipeline flush (mispredict).
- busy  out  1  slot valid OR scoreboard non-zero OR state != RUN.

Behaviour:
- Reset (async, rst_n=0):
  - slot invalid, so fu_valid=0 and fu_payload=0.
  - scoreboard=0, state=RUN, issue_q_ren=0, busy=0.
- Slot free: slot invalid, or slot valid and its selected fu_ready=1 this cycle.
- Hazard (uses the registered scoreboard only; no same-cycle writeback bypass):
  - RAW on rs1 when flags[3]=1 and sb[rs1]=1.
  - RAW on rs2 when flags[2]=1 and sb[rs2]=1.
  - WAW on rd when rd_wen=1 and sb[rd]=1.
  - Register x0 never hazards and is never set.
- Dispatch condition: issue_q_rok, slot free, no hazard, state=RUN, flush=0, plus the CSR rule below. issue_q_ren is combinational on this condition. The slot loads on the same edge; fu_valid rises next cycle.
- Latency and throughput: latency 1 cycle. Throughput 1 per cycle while the FU holds ready=1.
- Scoreboard updates:
  - On dispatch with rd_wen=1 and rd!=0, set sb[rd].
  - Each wb_valid[i] clears sb[wb_rd[i]].
  - Set and clear never target the same register in one cycle, because WAW stalls prevent it.
- State machine:
  - RUN: dispatch of a BPU op goes to BR_WAIT. Dispatch of a CSR op is permitted only when the slot is invalid and the scoreboard is all zero; it then goes to SER_WAIT.
  - BR_WAIT: no dispatch. br_resolve=1 returns to RUN; dispatch may resume the following cycle.
  - SER_WAIT: no dispatch. When the slot is invalid and the scoreboard is zero, return to RUN.
- flush=1:
  - Slot invalidated (dropped even if the FU is ready that cycle).
  - State forced to RUN; no pop that cycle.
  - Scoreboard kept, since older in-flight ops still write back.
- flush and br_resolve in the same cycle: flush takes precedence; the result is the same RUN state.
- Slot stability: slot contents stay stable while valid and not accepted. fu_valid never drops without acceptance or flush.

Optional Feature:
- Macro: DISPATCH_PERF_CNT_EN.
- When defined, add output stall_raw_cnt (32) and output stall_ser_cnt (32), both saturating at 0xFFFFFFFF and reset to 0.
  - stall_raw_cnt increments each cycle with issue_q_rok=1 that is blocked by a hazard.
  - stall_ser_cnt increments each cycle with issue_q_rok=1 that is blocked by BR_WAIT, SER_WAIT or the CSR drain rule.
- When not defined, these ports and their logic are absent.

Test Plan:
- Back-to-back ALU: add x1 then addi x2 (no dependency), fu_ready[0]=1 throughout -> issue_q_ren high 2 consecutive cycles; fu_valid=4'b0001 on cycles N+1 and N+2; sb[1]=sb[2]=1.
- RAW stall: add x3 dispatched; next entry reads rs1=x3; wb_valid[0] with wb_rd=3 arrives 4 cycles later -> dependent pop held 4 cycles; pops on the cycle after the writeback.
- Backpressure: LSU load, fu_ready[1]=0 for 3 cycles -> fu_valid[1] high and fu_payload constant for 3 cycles; no pops; accepted on cycle 4.
- Branch serialisation: beq followed by an ALU op -> after beq dispatch, no pop until br_resolve; ALU op pops the cycle after resolve. Repeat with flush instead of resolve: slot cleared, state RUN.
- CSR drain: csrrw issued while sb[5]=1 -> no pop until wb clears x5; CSR then dispatched, fu_valid=4'b1000; next op waits until CSR writeback clears its rd.
- Reset mid-operation: assert rst_n=0 with slot valid and sb non-zero -> fu_valid=0, busy=0, scoreboard cleared immediately without waiting for clk.
